// File: rtl/jk_pkg.sv
// Shared definitions for the JK excitation writer and the reusable excitation table.
package jk_pkg;

    // Request operation encodings carried on Req_Op.
    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_SET  = 2'b01,
        OP_CLR  = 2'b10,
        OP_TGL  = 2'b11
    } jk_op_e;

    // Write sequencer states.
    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_DRIVE  = 2'b01,
        S_VERIFY = 2'b10
    } jk_state_e;

    // Excitation cases, indexed by {current Q, target Q} of one flip-flop.
    localparam logic [1:0] EXC_STAY0 = 2'b00;  // 0 -> 0
    localparam logic [1:0] EXC_RISE  = 2'b01;  // 0 -> 1
    localparam logic [1:0] EXC_FALL  = 2'b10;  // 1 -> 0
    localparam logic [1:0] EXC_STAY1 = 2'b11;  // 1 -> 1

    localparam int unsigned RETRY_W = 3;

endpackage

// File: rtl/jk_excite.sv
// Combinational JK excitation table: per bit, the J/K pair that moves cur to tgt.
// Don't-care positions are driven with DONT_CARE_VAL; either value is correct.
module jk_excite
    import jk_pkg::*;
#(
    parameter int unsigned WIDTH         = 8,
    parameter bit          DONT_CARE_VAL = 1'b0
) (
    input  logic [WIDTH-1:0] cur_i,
    input  logic [WIDTH-1:0] tgt_i,
    output logic [WIDTH-1:0] j_o,
    output logic [WIDTH-1:0] k_o
);

    // Per-bit lookup of the excitation table.
    always_comb begin
        j_o = '0;
        k_o = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            case ({cur_i[i], tgt_i[i]})
                EXC_STAY0: begin
                    j_o[i] = 1'b0;
                    k_o[i] = DONT_CARE_VAL;
                end
                EXC_RISE: begin
                    j_o[i] = 1'b1;
                    k_o[i] = DONT_CARE_VAL;
                end
                EXC_FALL: begin
                    j_o[i] = DONT_CARE_VAL;
                    k_o[i] = 1'b1;
                end
                EXC_STAY1: begin
                    j_o[i] = DONT_CARE_VAL;
                    k_o[i] = 1'b0;
                end
                default: begin
                    j_o[i] = 1'b0;
                    k_o[i] = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/jk_excitation_writer.sv
// Write-side driver for a JK flip-flop register bank: computes the target word,
// drives one excitation cycle, verifies the readback and retries on mismatch.
module jk_excitation_writer
    import jk_pkg::*;
#(
    parameter int unsigned WIDTH         = 8,
    parameter bit          DONT_CARE_VAL = 1'b0,
    parameter int unsigned MAX_RETRY     = 2
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Req_Valid,
    output logic             Req_Ready,
    input  logic [1:0]       Req_Op,
    input  logic [WIDTH-1:0] Req_Data,
    input  logic [WIDTH-1:0] Q_In,
    output logic [WIDTH-1:0] J,
    output logic [WIDTH-1:0] K,
    output logic             Busy,
    output logic             Done,
    output logic             Err
);

    localparam logic [RETRY_W-1:0] MAX_RETRY_C = RETRY_W'(MAX_RETRY);

    jk_state_e          state_q, state_d;
    logic [WIDTH-1:0]   target_q, target_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [WIDTH-1:0]   j_q, j_d;
    logic [WIDTH-1:0]   k_q, k_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic [WIDTH-1:0]   req_target_s;
    logic [WIDTH-1:0]   exc_tgt_s;
    logic [WIDTH-1:0]   exc_j_s;
    logic [WIDTH-1:0]   exc_k_s;

    // Target word for an incoming request, built from the current readback.
    always_comb begin
        req_target_s = Req_Data;
        case (jk_op_e'(Req_Op))
            OP_LOAD: req_target_s = Req_Data;
            OP_SET:  req_target_s = Q_In | Req_Data;
            OP_CLR:  req_target_s = Q_In & ~Req_Data;
            OP_TGL:  req_target_s = Q_In ^ Req_Data;
            default: req_target_s = Req_Data;
        endcase
    end

    // A fresh request excites towards its new target; a retry reuses the latched one.
    always_comb begin
        if (state_q == S_IDLE) begin
            exc_tgt_s = req_target_s;
        end else begin
            exc_tgt_s = target_q;
        end
    end

    jk_excite #(
        .WIDTH         (WIDTH),
        .DONT_CARE_VAL (DONT_CARE_VAL)
    ) u_excite (
        .cur_i (Q_In),
        .tgt_i (exc_tgt_s),
        .j_o   (exc_j_s),
        .k_o   (exc_k_s)
    );

    // Sequencer next state and next registered outputs.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        retry_d  = retry_q;
        j_d      = '0;
        k_d      = '0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Req_Valid) begin
                    target_d = req_target_s;
                    retry_d  = '0;
                    j_d      = exc_j_s;
                    k_d      = exc_k_s;
                    state_d  = S_DRIVE;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_DRIVE: begin
                state_d = S_VERIFY;
            end
            S_VERIFY: begin
                if (Q_In == target_q) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (retry_q < MAX_RETRY_C) begin
                    retry_d = retry_q + 3'd1;
                    j_d     = exc_j_s;
                    k_d     = exc_k_s;
                    state_d = S_DRIVE;
                end else begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset that aborts any write.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            target_q <= '0;
            retry_q  <= '0;
            j_q      <= '0;
            k_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            retry_q  <= retry_d;
            j_q      <= j_d;
            k_q      <= k_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign Req_Ready = (state_q == S_IDLE);
    assign J         = j_q;
    assign K         = k_q;
    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Err       = err_q;

endmodule

// File: tb/tb_jk_excitation_writer.sv
// Directed bench: two writers (don't-care 0 and 1), each driving a modelled 4-bit JK bank.
module tb_jk_excitation_writer;

    localparam int W = 4;

    logic         Clk = 1'b0;
    logic         Reset;
    logic         Req_Valid;
    logic [1:0]   Req_Op;
    logic [W-1:0] Req_Data;

    logic [W-1:0] bank0, bank1;
    logic [W-1:0] j0, k0, j1, k1;
    logic         rdy0, busy0, done0, err0;
    logic         rdy1, busy1, done1, err1;

    logic         bank_force;
    logic [W-1:0] force_val;
    logic [W-1:0] stuck0;

    int n_checks = 0;
    int n_fail   = 0;
    int drives   = 0;

    always #5 Clk = ~Clk;

    jk_excitation_writer #(.WIDTH(W), .DONT_CARE_VAL(1'b0), .MAX_RETRY(2)) dut0 (
        .Clk(Clk), .Reset(Reset), .Req_Valid(Req_Valid), .Req_Ready(rdy0),
        .Req_Op(Req_Op), .Req_Data(Req_Data), .Q_In(bank0),
        .J(j0), .K(k0), .Busy(busy0), .Done(done0), .Err(err0)
    );

    jk_excitation_writer #(.WIDTH(W), .DONT_CARE_VAL(1'b1), .MAX_RETRY(2)) dut1 (
        .Clk(Clk), .Reset(Reset), .Req_Valid(Req_Valid), .Req_Ready(rdy1),
        .Req_Op(Req_Op), .Req_Data(Req_Data), .Q_In(bank1),
        .J(j1), .K(k1), .Busy(busy1), .Done(done1), .Err(err1)
    );

    // JK bank models: Qn = J&~Q | ~K&Q; bank0 can have bits stuck at 0.
    always @(posedge Clk) begin
        if (bank_force) begin
            bank0 <= force_val;
            bank1 <= force_val;
        end else begin
            bank0 <= ((j0 & ~bank0) | (~k0 & bank0)) & ~stuck0;
            bank1 <= (j1 & ~bank1) | (~k1 & bank1);
        end
    end

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a request for one cycle; returns at the negedge inside the DRIVE cycle.
    task automatic send(input logic [1:0] op, input logic [W-1:0] d);
        Req_Valid = 1'b1;
        Req_Op    = op;
        Req_Data  = d;
        @(negedge Clk);
        Req_Valid = 1'b0;
    endtask

    initial begin
        Reset      = 1'b1;
        Req_Valid  = 1'b0;
        Req_Op     = 2'b00;
        Req_Data   = 4'b0000;
        bank_force = 1'b1;
        force_val  = 4'b0000;
        stuck0     = 4'b0000;
        repeat (2) @(negedge Clk);
        Reset      = 1'b0;
        bank_force = 1'b0;
        @(negedge Clk);
        check_eq("rst_ready", 8'(rdy0), 8'd1);
        check_eq("rst_j", 8'(j0), 8'h0);
        check_eq("rst_k", 8'(k0), 8'h0);
        check_eq("rst_busy", 8'(busy0), 8'd0);
        check_eq("rst_done", 8'(done0), 8'd0);
        check_eq("rst_err", 8'(err0), 8'd0);

        // Load 1010 from 0000, don't-care 0.
        send(2'b00, 4'b1010);
        check_eq("ld_j", 8'(j0), 8'h0A);
        check_eq("ld_k", 8'(k0), 8'h00);
        check_eq("ld_busy", 8'(busy0), 8'd1);
        check_eq("ld_ready", 8'(rdy0), 8'd0);
        check_eq("ld_done_early", 8'(done0), 8'd0);
        @(negedge Clk);
        check_eq("ld_bank", 8'(bank0), 8'h0A);
        check_eq("ld_verify_j", 8'(j0), 8'h00);
        check_eq("ld_verify_busy", 8'(busy0), 8'd1);
        check_eq("ld_verify_done", 8'(done0), 8'd0);
        @(negedge Clk);
        check_eq("ld_done", 8'(done0), 8'd1);
        check_eq("ld_err", 8'(err0), 8'd0);
        check_eq("ld_ready_again", 8'(rdy0), 8'd1);
        check_eq("ld_busy_off", 8'(busy0), 8'd0);
        @(negedge Clk);
        check_eq("ld_done_pulse", 8'(done0), 8'd0);

        // Toggle 0110 on 1010 -> target 1100.
        send(2'b11, 4'b0110);
        check_eq("tgl_j", 8'(j0), 8'h04);
        check_eq("tgl_k", 8'(k0), 8'h02);
        @(negedge Clk);
        check_eq("tgl_bank", 8'(bank0), 8'h0C);
        @(negedge Clk);
        check_eq("tgl_done", 8'(done0), 8'd1);
        // Back-to-back: accept a load of 0011 during the Done cycle.
        send(2'b00, 4'b0011);
        check_eq("b2b_busy", 8'(busy0), 8'd1);
        check_eq("b2b_done_off", 8'(done0), 8'd0);
        check_eq("b2b_j", 8'(j0), 8'h03);
        check_eq("b2b_k", 8'(k0), 8'h0C);
        @(negedge Clk);
        @(negedge Clk);
        check_eq("b2b_done1", 8'(done1), 8'd1);
        check_eq("b2b_bank1", 8'(bank1), 8'h03);
        @(negedge Clk);

        // Don't-care 1: set 0101 on 0011 -> target 0111.
        send(2'b01, 4'b0101);
        check_eq("set_dc1_j", 8'(j1), 8'h07);
        check_eq("set_dc1_k", 8'(k1), 8'h0C);
        @(negedge Clk);
        check_eq("set_dc1_bank", 8'(bank1), 8'h07);
        @(negedge Clk);
        check_eq("set_dc1_done", 8'(done1), 8'd1);
        check_eq("set_dc1_err", 8'(err1), 8'd0);
        @(negedge Clk);

        // Bit0 of bank0 stuck at 0: load 0001 retries twice then errors.
        bank_force = 1'b1;
        force_val  = 4'b0000;
        stuck0     = 4'b0001;
        @(negedge Clk);
        bank_force = 1'b0;
        check_eq("stuck_preset", 8'(bank0), 8'h00);
        send(2'b00, 4'b0001);
        for (int i = 1; i <= 7; i++) begin
            check_eq($sformatf("stuck_j_c%0d", i), 8'(j0), ((i % 2 == 1) && (i < 7)) ? 8'h01 : 8'h00);
            check_eq($sformatf("stuck_err_c%0d", i), 8'(err0), (i == 7) ? 8'd1 : 8'd0);
            check_eq($sformatf("stuck_done_c%0d", i), 8'(done0), 8'd0);
            if (j0 == 4'b0001) drives++;
            @(negedge Clk);
        end
        check_eq("stuck_err_pulse", 8'(err0), 8'd0);
        check_eq("stuck_drives", 8'(drives), 8'd3);
        stuck0 = 4'b0000;

        // Reset during DRIVE aborts silently, held for two cycles.
        send(2'b00, 4'b1010);
        Reset = 1'b1;
        @(negedge Clk);
        check_eq("abort_j", 8'(j0), 8'h00);
        check_eq("abort_k", 8'(k0), 8'h00);
        check_eq("abort_busy", 8'(busy0), 8'd0);
        check_eq("abort_done", 8'(done0), 8'd0);
        check_eq("abort_err", 8'(err0), 8'd0);
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        check_eq("abort_ready", 8'(rdy0), 8'd1);
        check_eq("abort_done2", 8'(done0), 8'd0);
        check_eq("abort_err2", 8'(err0), 8'd0);
        // Bank holds 1010 from the aborted drive edge; load 1111.
        send(2'b00, 4'b1111);
        check_eq("fresh_j", 8'(j0), 8'h05);
        check_eq("fresh_k", 8'(k0), 8'h00);
        @(negedge Clk);
        @(negedge Clk);
        check_eq("fresh_done", 8'(done0), 8'd1);
        check_eq("fresh_bank", 8'(bank0), 8'h0F);
        @(negedge Clk);

        // Null request: set with empty mask still completes.
        send(2'b01, 4'b0000);
        check_eq("null_j", 8'(j0), 8'h00);
        check_eq("null_k", 8'(k0), 8'h00);
        check_eq("null_busy", 8'(busy0), 8'd1);
        @(negedge Clk);
        @(negedge Clk);
        check_eq("null_done", 8'(done0), 8'd1);
        check_eq("null_err", 8'(err0), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
